operand_load_shift: RTL and testbench

- Parametrised operand front-end for the sequential shift-add multiplier.
- On a start edge it captures multiplier and multiplicand and, in signed mode, converts each operand to its magnitude and computes the product sign.
- It then provides the shifting operand registers step by step to the sequencer, and holds the final state until the sequencer acknowledges.
- It sits between the operand inputs and the shift-add accumulator.

---
 rtl/operand_load_shift_pkg.sv | 26 ++
 rtl/operand_load_shift_sign_mag.sv | 23 ++
 rtl/operand_load_shift.sv | 132 +++++++++++++
 tb/tb_operand_load_shift.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/operand_load_shift_pkg.sv
// Shared constants, state encoding and width helpers for the shift-add
// multiplier operand front-end.
package operand_load_shift_pkg;

   localparam int   DW      = 16;
   localparam int   DW_2    = 2 * DW;
   localparam logic ONE     = 1'b1;
   localparam logic ZERO    = 1'b0;
   localparam int   BIT_LSB = 0;
   localparam int   BIT_MSB = DW - 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOADED = 2'd1,
      SHIFT  = 2'd2,
      HOLD   = 2'd3
   } state_t;

   // Step counter width: enough bits to count DW shifts, never narrower than 1.
   function automatic int cw_of(input int dw);
      int w;
      w = $clog2(dw);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/operand_load_shift_sign_mag.sv
// Sign/magnitude split of one operand; the most negative value maps to an
// exact unsigned magnitude because the negate wraps into the MSB.
module operand_load_shift_sign_mag #(
   parameter int W = 16
) (
   input  logic [W-1:0] value,
   input  logic         signed_mode,
   output logic [W-1:0] magnitude,
   output logic         sign
);

   // Negate only when the operand is treated as signed and is negative.
   always_comb begin
      sign      = signed_mode & value[W-1];
      magnitude = value;
      if (sign) begin
         magnitude = ~value + {{(W-1){1'b0}}, 1'b1};
      end else begin
         magnitude = value;
      end
   end

endmodule

// File: rtl/operand_load_shift.sv
// Operand front-end: captures operands on a start edge, converts to magnitude,
// then shifts them one step per sequencer strobe and holds until acknowledged.
module operand_load_shift
   import operand_load_shift_pkg::*;
#(
   parameter int DW   = operand_load_shift_pkg::DW,
   parameter int DW_2 = 2 * DW,
   parameter int CW   = cw_of(DW)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            signed_mode,
   input  logic [DW-1:0]   multiplier,
   input  logic [DW-1:0]   multiplicand,
   input  logic            shift_en,
   input  logic            ack,
   output logic            charged,
   output logic            busy,
   output logic [DW-1:0]   rgstr1,
   output logic [DW_2-1:0] rgstr2,
   output logic            lsb,
   output logic            neg_result,
   output logic [CW-1:0]   step_cnt,
   output logic            last_step
);

   state_t          state;
   state_t          next_state;
   logic            start_q;
   logic            start_edge;
   logic            load;
   logic            shift_go;
   logic [DW-1:0]   mag1;
   logic [DW-1:0]   mag2;
   logic            sign1;
   logic            sign2;

   operand_load_shift_sign_mag #(.W(DW)) u_mag_mplier (
      .value       (multiplier),
      .signed_mode (signed_mode),
      .magnitude   (mag1),
      .sign        (sign1)
   );

   operand_load_shift_sign_mag #(.W(DW)) u_mag_mcand (
      .value       (multiplicand),
      .signed_mode (signed_mode),
      .magnitude   (mag2),
      .sign        (sign2)
   );

   assign start_edge = start & ~start_q;
   assign last_step  = (state == SHIFT) && (step_cnt == CW'(DW - 1));
   assign busy       = (state != IDLE);
   assign charged    = (state == LOADED);
   assign lsb        = rgstr1[0];

   // State register and start edge history.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         start_q <= ZERO;
      end else begin
         state   <= next_state;
         start_q <= start;
      end
   end

   // Next-state decode; start and ack only matter in IDLE and HOLD respectively.
   always_comb begin
      next_state = state;
      load       = ZERO;
      shift_go   = ZERO;
      case (state)
         IDLE: begin
            if (start_edge) begin
               next_state = LOADED;
               load       = ONE;
            end else begin
               next_state = IDLE;
            end
         end
         LOADED: begin
            next_state = SHIFT;
         end
         SHIFT: begin
            if (shift_en) begin
               shift_go   = ONE;
               next_state = last_step ? HOLD : SHIFT;
            end else begin
               next_state = SHIFT;
            end
         end
         HOLD: begin
            if (ack) begin
               next_state = IDLE;
            end else begin
               next_state = HOLD;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Operand registers: load, shift, or hold; contents survive the return to IDLE.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rgstr1     <= {DW{1'b0}};
         rgstr2     <= {DW_2{1'b0}};
         neg_result <= ZERO;
         step_cnt   <= {CW{1'b0}};
      end else if (load) begin
         rgstr1     <= mag1;
         rgstr2     <= {{DW{1'b0}}, mag2};
         neg_result <= sign1 ^ sign2;
         step_cnt   <= {CW{1'b0}};
      end else if (shift_go) begin
         rgstr1     <= rgstr1 >> 1;
         rgstr2     <= rgstr2 << 1;
         step_cnt   <= last_step ? {CW{1'b0}} : step_cnt + CW'(1);
      end else begin
         rgstr1     <= rgstr1;
         rgstr2     <= rgstr2;
         neg_result <= neg_result;
         step_cnt   <= step_cnt;
      end
   end

endmodule

// File: tb/tb_operand_load_shift.sv
// Directed self-checking bench for operand_load_shift at DW=8.
module tb_operand_load_shift;

   localparam int DW   = 8;
   localparam int DW_2 = 16;
   localparam int CW   = 3;

   logic            clk;
   logic            rst;
   logic            start;
   logic            signed_mode;
   logic [DW-1:0]   multiplier;
   logic [DW-1:0]   multiplicand;
   logic            shift_en;
   logic            ack;
   logic            charged;
   logic            busy;
   logic [DW-1:0]   rgstr1;
   logic [DW_2-1:0] rgstr2;
   logic            lsb;
   logic            neg_result;
   logic [CW-1:0]   step_cnt;
   logic            last_step;

   int tests;
   int fails;

   operand_load_shift #(.DW(DW)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .signed_mode  (signed_mode),
      .multiplier   (multiplier),
      .multiplicand (multiplicand),
      .shift_en     (shift_en),
      .ack          (ack),
      .charged      (charged),
      .busy         (busy),
      .rgstr1       (rgstr1),
      .rgstr2       (rgstr2),
      .lsb          (lsb),
      .neg_result   (neg_result),
      .step_cnt     (step_cnt),
      .last_step    (last_step)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_regs(input string tag, input logic [7:0] e1, input logic [15:0] e2,
                             input logic en, input logic ecg, input logic ebusy);
      check({tag, ".rgstr1"}, {24'd0, rgstr1}, {24'd0, e1});
      check({tag, ".rgstr2"}, {16'd0, rgstr2}, {16'd0, e2});
      check({tag, ".neg"}, {31'd0, neg_result}, {31'd0, en});
      check({tag, ".charged"}, {31'd0, charged}, {31'd0, ecg});
      check({tag, ".busy"}, {31'd0, busy}, {31'd0, ebusy});
   endtask

   task automatic run_to_idle();
      shift_en = 1'b1;
      repeat (9) tick();
      check("run.hold_busy", {31'd0, busy}, 32'd1);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      check("run.idle", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      logic [7:0]  e1;
      logic [15:0] e2;
      tests = 0;
      fails = 0;
      rst = 1'b0; start = 1'b0; signed_mode = 1'b0; multiplier = 8'h00;
      multiplicand = 8'h00; shift_en = 1'b0; ack = 1'b0;

      #3;
      check_regs("reset", 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0);
      check("reset.cnt", {29'd0, step_cnt}, 32'd0);
      check("reset.last", {31'd0, last_step}, 32'd0);
      tick();
      rst = 1'b1;
      tick();
      check("idle.busy", {31'd0, busy}, 32'd0);

      // Unsigned 11 x 13 with continuous shifting
      multiplier = 8'h0B; multiplicand = 8'h0D; signed_mode = 1'b0; shift_en = 1'b1;
      start = 1'b1;
      tick();
      check_regs("u.load", 8'h0B, 16'h000D, 1'b0, 1'b1, 1'b1);
      check("u.cnt0", {29'd0, step_cnt}, 32'd0);
      check("u.lsb", {31'd0, lsb}, 32'd1);
      start = 1'b0;
      tick();
      check_regs("u.loaded_noshift", 8'h0B, 16'h000D, 1'b0, 1'b0, 1'b1);
      e1 = 8'h0B;
      e2 = 16'h000D;
      for (int i = 0; i < 8; i++) begin
         check("u.step_cnt", {29'd0, step_cnt}, i);
         check("u.last_step", {31'd0, last_step}, (i == 7) ? 32'd1 : 32'd0);
         check("u.r1_step", {24'd0, rgstr1}, {24'd0, e1});
         check("u.r2_step", {16'd0, rgstr2}, {16'd0, e2});
         tick();
         e1 = e1 >> 1;
         e2 = e2 << 1;
      end
      check_regs("u.hold", 8'h00, 16'h0D00, 1'b0, 1'b0, 1'b1);
      check("u.hold_cnt", {29'd0, step_cnt}, 32'd0);
      check("u.hold_last", {31'd0, last_step}, 32'd0);

      // Start edge in HOLD is ignored; holding it through ack gives no reload
      multiplier = 8'h55; multiplicand = 8'h66;
      start = 1'b1;
      tick();
      check_regs("hold.start_ign", 8'h00, 16'h0D00, 1'b0, 1'b0, 1'b1);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      check_regs("ack.idle", 8'h00, 16'h0D00, 1'b0, 1'b0, 1'b0);
      tick();
      tick();
      check_regs("ack.no_reload", 8'h00, 16'h0D00, 1'b0, 1'b0, 1'b0);
      start = 1'b0;
      tick();

      // Signed -3 x 5
      multiplier = 8'hFD; multiplicand = 8'h05; signed_mode = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      check_regs("s.m3x5", 8'h03, 16'h0005, 1'b1, 1'b1, 1'b1);
      run_to_idle();
      check("s.neg_persist", {31'd0, neg_result}, 32'd1);

      // Same operands, unsigned
      signed_mode = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      check_regs("u.fdx5", 8'hFD, 16'h0005, 1'b0, 1'b1, 1'b1);
      run_to_idle();

      // Most negative value in both operands
      multiplier = 8'h80; multiplicand = 8'h80; signed_mode = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      check_regs("s.m128", 8'h80, 16'h0080, 1'b0, 1'b1, 1'b1);
      check("s.m128_lsb", {31'd0, lsb}, 32'd0);
      run_to_idle();

      // Shift gaps, ignored start and ack in SHIFT
      multiplier = 8'h0B; multiplicand = 8'h0D; signed_mode = 1'b0; shift_en = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      check("gap.cnt0", {29'd0, step_cnt}, 32'd0);
      shift_en = 1'b1;
      tick();
      check_regs("gap.s1", 8'h05, 16'h001A, 1'b0, 1'b0, 1'b1);
      shift_en = 1'b0; ack = 1'b1; start = 1'b1;
      multiplier = 8'hAA;
      tick();
      ack = 1'b0; start = 1'b0;
      check_regs("gap.z1", 8'h05, 16'h001A, 1'b0, 1'b0, 1'b1);
      check("gap.z1_cnt", {29'd0, step_cnt}, 32'd1);
      tick();
      check("gap.z2_cnt", {29'd0, step_cnt}, 32'd1);
      shift_en = 1'b1;
      tick();
      check_regs("gap.s2", 8'h02, 16'h0034, 1'b0, 1'b0, 1'b1);
      check("gap.s2_cnt", {29'd0, step_cnt}, 32'd2);
      tick();
      check("gap.s3_cnt", {29'd0, step_cnt}, 32'd3);

      // Asynchronous reset mid-operation with start held across release
      start = 1'b1; multiplier = 8'hFB; multiplicand = 8'h03; signed_mode = 1'b1;
      #2 rst = 1'b0;
      #1;
      check_regs("rst.mid", 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0);
      check("rst.mid_cnt", {29'd0, step_cnt}, 32'd0);
      check("rst.mid_last", {31'd0, last_step}, 32'd0);
      #2 rst = 1'b1;
      tick();
      check_regs("rst.reload", 8'h05, 16'h0003, 1'b1, 1'b1, 1'b1);
      tick();
      check("rst.one_charge", {31'd0, charged}, 32'd0);
      repeat (8) tick();
      check_regs("rst.hold", 8'h00, 16'h0300, 1'b1, 1'b0, 1'b1);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      tick();
      tick();
      check_regs("rst.no_second", 8'h00, 16'h0300, 1'b1, 1'b0, 1'b0);
      start = 1'b0;
      tick();
      start = 1'b1;
      tick();
      check_regs("retrigger", 8'h05, 16'h0003, 1'b1, 1'b1, 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
